async_fifo_reader: RTL and testbench
====================================

# async_fifo_reader

Read-side consumer engine for `async_fifo`, running entirely in the `rd_clk` domain. It drains the FIFO by issuing `rd_en` whenever data is present and local space exists, and captures `rd_data` after the FIFO's read latency. It re-presents the words on a valid/ready stream to downstream logic at full throughput, and keeps a running count of delivered words. It is the receiving end of the FIFO interface that the write-side producer feeds.

## Interface
- `DATA_WIDTH`, 8: word width; matches the FIFO `rd_data` width.
- `RD_LAT`, 1: cycles from `rd_en` high to `rd_data` valid. Legal values are 1 or 2.
- `CNT_WIDTH`, 16: width of the delivered-word counter.
- `rd_clk` in, 1: the single clock for the block.
- `rd_rst` in, 1: synchronous, active-high reset.
- `en` in, 1: permission to fetch new words from the FIFO.
- `fifo_empty` in, 1: FIFO empty flag, registered in `rd_clk`.
- `rd_data` in, `DATA_WIDTH`: FIFO read data.
- `rd_en` out, 1: FIFO read strobe.
- `out_valid` out, 1: output word available.
- `out_ready` in, 1: downstream accepts the output word.
- `out_data` out, `DATA_WIDTH`: head word of the local buffer.
- `rd_count` out, `CNT_WIDTH`: number of words transferred on the output, wrapping.
- `busy` out, 1: high while any word is in flight or buffered.

## Operation
- Local buffer: `BUF_DEPTH = RD_LAT+2` entries, FIFO-ordered.
- `occ` = occupancy of the local buffer.
- `infl` = number of reads issued whose data has not yet been captured.
- `rd_en = !rd_rst && en && !fifo_empty && (occ + infl < BUF_DEPTH)`. It must not depend on `out_ready`.
- Underflow cannot occur: `rd_en` is gated by `!fifo_empty`, and the FIFO's empty flag reflects every prior read by the next edge.
- Overflow of the local buffer is impossible by the credit rule above. A bench assertion checks this.
- Capture: a valid-bit shift register `RD_LAT` deep tracks each read. When a bit reaches the end, `rd_data` is written into the buffer on that edge.
- Output handshake:
  - `out_valid = (occ != 0)`; `out_data` is the buffer head.
  - A transfer occurs on a cycle with `out_valid && out_ready`.
  - `out_data` holds stable while `out_valid && !out_ready`.
- A push and a pop in the same cycle leave `occ` unchanged.
- `rd_count` increments by 1 per output transfer and wraps from `2^CNT_WIDTH-1` to 0.
- State machine `st`:
  - IDLE: `en=0` and nothing pending.
  - RUN: `en=1`.
  - STOP: `en=0` with `infl+occ > 0`.
  - IDLE→RUN when `en=1`.
  - RUN→STOP when `en=0` and `infl+occ > 0`.
  - RUN→IDLE when `en=0` and nothing is pending.
  - STOP→RUN when `en=1`.
  - STOP→IDLE when in-flight and buffered words have landed and been delivered.
  - `busy = (st != IDLE) && (infl+occ > 0)`.
- Deasserting `en` stops new reads immediately (combinational). In-flight words still land and are delivered.
- Reset mid-operation clears in-flight and buffered words. They are lost, and the FIFO read pointer is not rewound. This is the intended behaviour; the FIFO's read domain is reset alongside.

## Timing
- Reset values:
  - `rd_en` = 0.
  - `out_valid` = 0.
  - `out_data` = 0.
  - `rd_count` = 0.
  - `busy` = 0.
  - `st` = IDLE.
  - `occ` = `infl` = 0.
- Latency: with `rd_en` high in cycle t, `rd_data` is sampled at the end of cycle t+`RD_LAT`, and `out_valid` rises in cycle t+`RD_LAT`+1.
- Throughput: with `fifo_empty=0`, `en=1` and `out_ready=1`, the block sustains one word per cycle indefinitely.
- Backpressure: with `out_ready=0`, `rd_en` stops after at most `BUF_DEPTH` reads.
- Resume: after `out_ready` returns high, `rd_en` reasserts on the cycle following the first pop.

## Structure
- Package `async_fifo_reader_pkg`:
  - state enum {IDLE, RUN, STOP}.
  - function `buf_depth(rd_lat)`.
- Sub-module `rd_buf`: a synchronous `BUF_DEPTH`-entry register FIFO with push/pop, `occ` output and head output. The top level holds the credit logic, the latency shift register, the counter and the FSM.

## Test plan
- Reset then idle:
  - Stimulus: `fifo_empty=1`, `en=1` for 20 cycles.
  - Required: `rd_en` never rises; all outputs stay at reset values.
- Streaming (`RD_LAT=1`):
  - Stimulus: FIFO model preloaded with 10 bytes in 100..109, `out_ready=1`.
  - Required: first `out_valid` two cycles after first `rd_en`; 10 consecutive transfers in order; `rd_count=10`; `busy` low afterwards.
- Backpressure:
  - Stimulus: 10 words queued, `out_ready=0`.
  - Required: exactly 3 `rd_en` pulses (`RD_LAT=1`), `out_data` stable.
  - Then: release `out_ready`; all 10 words arrive in order with no loss or duplication.
- Stop mid-stream:
  - Stimulus: drop `en` after 4 reads with `RD_LAT=2`.
  - Required: `rd_en` low the same cycle; in-flight words still delivered; `st` goes RUN→STOP→IDLE.
- Reset mid-operation:
  - Stimulus: assert `rd_rst` with `occ=2`, `infl=1`.
  - Required: next cycle `out_valid=0`, `rd_count=0`, `busy=0`.
- Counter wrap:
  - Stimulus: `CNT_WIDTH=4`, 17 transfers.
  - Required: `rd_count=1`.

Source files
------------

// File: rtl/async_fifo_reader_pkg.sv
// Shared types and sizing helpers for the async_fifo read-side consumer.
package async_fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Room for every read in flight plus one word being popped and one being captured.
    function automatic int unsigned buf_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/async_fifo_reader_rd_buf.sv
// Small register FIFO holding captured read words until the output stream takes them.
module async_fifo_reader_rd_buf
    import async_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [cnt_bits(DEPTH)-1:0]     occ,
    output logic [DATA_WIDTH-1:0]          head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = cnt_bits(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (occ_q != '0);
        do_push  = push && ((occ_q != OCC_W'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/async_fifo_reader.sv
// Read-side consumer for async_fifo: credit-gated reads, latency tracking,
// local buffering and a valid/ready output stream with a delivered-word counter.
module async_fifo_reader
    import async_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    localparam int unsigned BUF_DEPTH = buf_depth(RD_LAT);
    localparam int unsigned OCC_W     = cnt_bits(BUF_DEPTH);
    localparam int unsigned PEND_W    = OCC_W + 1;

    state_e                st_q, st_d;
    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      infl;
    logic [PEND_W-1:0]     pending;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    async_fifo_reader_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_rd_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    // Credits count buffered plus in-flight words; a same-cycle pop does not free one.
    always_comb begin
        infl = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            infl = infl + OCC_W'(vld_q[i]);
        end
        pending   = PEND_W'(occ) + PEND_W'(infl);
        rd_en     = !rd_rst && en && !fifo_empty && (pending < PEND_W'(BUF_DEPTH));
        vld_d     = RD_LAT'({vld_q, rd_en});
        push      = vld_q[RD_LAT-1];
        out_valid = (occ != '0);
        pop       = out_valid && out_ready;
        cnt_d     = cnt_q + CNT_WIDTH'(pop);
    end

    always_comb begin
        st_d = st_q;
        busy = 1'b0;
        case (st_q)
            IDLE: begin
                if (en) st_d = RUN;
            end
            RUN: begin
                if (!en) st_d = (pending != '0) ? STOP : IDLE;
            end
            STOP: begin
                if (en) begin
                    st_d = RUN;
                end else if (pending == '0) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
        busy = (st_q != IDLE) && (pending != '0);
    end

    // Reset drops anything in flight or buffered; the FIFO read side resets alongside.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            st_q  <= IDLE;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_data = head;
    assign rd_count = cnt_q;

endmodule

// File: tb/tb_async_fifo_reader.sv
// Bench for async_fifo_reader: instance a (RD_LAT=1, 16-bit count) and instance b
// (RD_LAT=2, 4-bit count), each fed by a queue-based FIFO model and scoreboard.
module tb_async_fifo_reader;
    import async_fifo_reader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, fifo_empty_a = 1'b1, out_ready_a = 1'b0;
    logic        rd_en_a, out_valid_a, busy_a;
    logic [7:0]  rd_data_a = 8'h00, out_data_a;
    logic [15:0] rd_count_a;

    logic        rst_b = 1'b1, en_b = 1'b0, fifo_empty_b = 1'b1, out_ready_b = 1'b0;
    logic        rd_en_b, out_valid_b, busy_b;
    logic [7:0]  rd_data_b = 8'h00, out_data_b, stage_b = 8'h00;
    logic [3:0]  rd_count_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rden_cnt_a = 0, rden_cnt_b = 0;
    int total_a = 0;
    logic [7:0] fq_a[$], fq_b[$], exp_a[$], exp_b[$], got_a[$], got_b[$];

    async_fifo_reader #(.DATA_WIDTH(8), .RD_LAT(1), .CNT_WIDTH(16)) u_a (
        .rd_clk(clk), .rd_rst(rst_a), .en(en_a), .fifo_empty(fifo_empty_a),
        .rd_data(rd_data_a), .rd_en(rd_en_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .rd_count(rd_count_a),
        .busy(busy_a)
    );

    async_fifo_reader #(.DATA_WIDTH(8), .RD_LAT(2), .CNT_WIDTH(4)) u_b (
        .rd_clk(clk), .rd_rst(rst_b), .en(en_b), .fifo_empty(fifo_empty_b),
        .rd_data(rd_data_b), .rd_en(rd_en_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .rd_count(rd_count_b),
        .busy(busy_b)
    );

    // FIFO models: data appears RD_LAT edges after the strobe; empty flag is registered.
    always @(posedge clk) begin
        if (rd_en_a && fq_a.size() != 0) rd_data_a <= fq_a.pop_front();
        fifo_empty_a <= (fq_a.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_en_b && fq_b.size() != 0) stage_b <= fq_b.pop_front();
        rd_data_b    <= stage_b;
        fifo_empty_b <= (fq_b.size() == 0);
    end

    // Mid-cycle monitor: strobe counts, accepted words, local-buffer overflow.
    always @(negedge clk) begin
        cyc++;
        if (rd_en_a) rden_cnt_a++;
        if (rd_en_b) rden_cnt_b++;
        if (out_valid_a && out_ready_a) got_a.push_back(out_data_a);
        if (out_valid_b && out_ready_b) got_b.push_back(out_data_b);
        assert (int'(u_a.occ) + int'(u_a.infl) <= 3 && int'(u_b.occ) + int'(u_b.infl) <= 4)
        else begin
            $error("FAIL buf_overflow occ_a=%0d infl_a=%0d occ_b=%0d infl_b=%0d",
                   u_a.occ, u_a.infl, u_b.occ, u_b.infl);
            miscompares++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) cycle();
        mid();
        vectors++;
        if (u_a.st_q !== IDLE || u_b.st_q !== IDLE) begin
            $display("FAIL reset_state: got a=%0d b=%0d expected %0d", u_a.st_q, u_b.st_q, IDLE);
            miscompares++;
        end
        cycle();
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mid();
            vectors++;
            if ({rd_en_a, out_valid_a, busy_a, out_data_a, rd_count_a} !== 27'd0) begin
                $display("FAIL idle_a cycle %0d: got rd_en=%b valid=%b busy=%b data=%0h cnt=%0d expected all zero",
                         i, rd_en_a, out_valid_a, busy_a, out_data_a, rd_count_a);
                miscompares++;
            end
            vectors++;
            if ({rd_en_b, out_valid_b, busy_b, out_data_b, rd_count_b} !== 15'd0) begin
                $display("FAIL idle_b cycle %0d: got rd_en=%b valid=%b busy=%b data=%0h cnt=%0d expected all zero",
                         i, rd_en_b, out_valid_b, busy_b, out_data_b, rd_count_b);
                miscompares++;
            end
            cycle();
        end
    endtask

    task automatic test_streaming();
        int first_rd, first_v, last_v, nv;
        first_rd = -1; first_v = -1; last_v = -1; nv = 0;
        got_a.delete(); exp_a.delete();
        cycle();
        out_ready_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fq_a.push_back(8'(100 + k));
            exp_a.push_back(8'(100 + k));
        end
        total_a += 10;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (rd_en_a && first_rd < 0) first_rd = cyc;
            if (out_valid_a) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                nv++;
            end
            cycle();
        end
        vectors++;
        if (first_rd < 0 || first_v - first_rd != 2) begin
            $display("FAIL stream_latency: got %0d cycles expected 2", first_v - first_rd);
            miscompares++;
        end
        vectors++;
        if (nv != 10 || last_v - first_v != 9) begin
            $display("FAIL stream_back_to_back: got %0d valid over %0d cycles expected 10 over 10",
                     nv, last_v - first_v + 1);
            miscompares++;
        end
        vectors++;
        if (got_a.size() != 10) begin
            $display("FAIL stream_words: got %0d expected 10", got_a.size());
            miscompares++;
        end
        for (int k = 0; k < got_a.size() && k < 10; k++) begin
            vectors++;
            if (got_a[k] !== exp_a[k]) begin
                $display("FAIL stream_order[%0d]: got %0d expected %0d", k, got_a[k], exp_a[k]);
                miscompares++;
            end
        end
        mid();
        vectors++;
        if (rd_count_a !== 16'(total_a) || busy_a !== 1'b0) begin
            $display("FAIL stream_end: got cnt=%0d busy=%b expected cnt=%0d busy=0",
                     rd_count_a, busy_a, total_a);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        int start, unstable, done;
        logic have;
        logic [7:0] held;
        unstable = 0; have = 1'b0; held = 8'h00; done = 0;
        got_a.delete(); exp_a.delete();
        cycle();
        out_ready_a = 1'b0;
        start = rden_cnt_a;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            fq_a.push_back(w);
            exp_a.push_back(w);
        end
        total_a += 10;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (out_valid_a) begin
                if (!have) begin
                    held = out_data_a;
                    have = 1'b1;
                end else if (out_data_a !== held) begin
                    unstable++;
                end
            end
            cycle();
        end
        vectors++;
        if (rden_cnt_a - start != 3) begin
            $display("FAIL bp_reads: got %0d expected 3", rden_cnt_a - start);
            miscompares++;
        end
        vectors++;
        if (!have || unstable != 0) begin
            $display("FAIL bp_stable: got valid_seen=%b changes=%0d expected valid_seen=1 changes=0",
                     have, unstable);
            miscompares++;
        end
        out_ready_a = 1'b1;
        mid();
        vectors++;
        if (rd_en_a !== 1'b0) begin
            $display("FAIL bp_first_pop_rd_en: got %b expected 0", rd_en_a);
            miscompares++;
        end
        cycle();
        mid();
        vectors++;
        if (rd_en_a !== 1'b1) begin
            $display("FAIL bp_resume_rd_en: got %b expected 1", rd_en_a);
            miscompares++;
        end
        for (int i = 0; i < 60 && done == 0; i++) begin
            cycle();
            mid();
            if (got_a.size() >= 10) done = 1;
        end
        vectors++;
        if (got_a.size() != 10) begin
            $display("FAIL bp_words: got %0d expected 10", got_a.size());
            miscompares++;
        end
        for (int k = 0; k < got_a.size() && k < 10; k++) begin
            vectors++;
            if (got_a[k] !== exp_a[k]) begin
                $display("FAIL bp_order[%0d]: got %0h expected %0h", k, got_a[k], exp_a[k]);
                miscompares++;
            end
        end
        cycle();
        mid();
        vectors++;
        if (rd_count_a !== 16'(total_a) || busy_a !== 1'b0) begin
            $display("FAIL bp_end: got cnt=%0d busy=%b expected cnt=%0d busy=0",
                     rd_count_a, busy_a, total_a);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic       stall;
        logic [7:0] stall_data;
        int         done;
        stall = 1'b0; stall_data = 8'h00; done = 0;
        got_a.delete(); exp_a.delete();
        for (int i = 0; i < 400; i++) begin
            cycle();
            out_ready_a = ($urandom_range(0, 9) < 7);
            en_a        = ($urandom_range(0, 9) < 9);
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] w;
                w = 8'($urandom);
                fq_a.push_back(w);
                exp_a.push_back(w);
                total_a++;
            end
            mid();
            if (stall) begin
                vectors++;
                if (out_valid_a !== 1'b1 || out_data_a !== stall_data) begin
                    $display("FAIL rand_hold cycle %0d: got valid=%b data=%0h expected valid=1 data=%0h",
                             i, out_valid_a, out_data_a, stall_data);
                    miscompares++;
                end
            end
            stall      = out_valid_a && !out_ready_a;
            stall_data = out_data_a;
        end
        cycle();
        en_a = 1'b1;
        out_ready_a = 1'b1;
        for (int i = 0; i < 300 && done == 0; i++) begin
            mid();
            if (got_a.size() >= exp_a.size() && fq_a.size() == 0) done = 1;
            cycle();
        end
        vectors++;
        if (got_a.size() != exp_a.size()) begin
            $display("FAIL rand_words: got %0d expected %0d", got_a.size(), exp_a.size());
            miscompares++;
        end
        for (int k = 0; k < got_a.size() && k < exp_a.size(); k++) begin
            vectors++;
            if (got_a[k] !== exp_a[k]) begin
                $display("FAIL rand_order[%0d]: got %0h expected %0h", k, got_a[k], exp_a[k]);
                miscompares++;
            end
        end
        mid();
        vectors++;
        if (rd_count_a !== 16'(total_a) || busy_a !== 1'b0) begin
            $display("FAIL rand_end: got cnt=%0d busy=%b expected cnt=%0d busy=0",
                     rd_count_a, busy_a, 16'(total_a));
            miscompares++;
        end
    endtask

    task automatic test_stop();
        int start, first_rd, first_v, found, idle;
        logic saw_stop;
        first_rd = -1; first_v = -1; found = 0; idle = 0; saw_stop = 1'b0;
        got_b.delete(); exp_b.delete(); fq_b.delete();
        cycle();
        out_ready_b = 1'b1;
        en_b = 1'b1;
        start = rden_cnt_b;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            fq_b.push_back(w);
            exp_b.push_back(w);
        end
        for (int i = 0; i < 30 && found == 0; i++) begin
            mid();
            if (rd_en_b && first_rd < 0) first_rd = cyc;
            if (out_valid_b && first_v < 0) first_v = cyc;
            if (rden_cnt_b - start == 4) found = 1;
            else cycle();
        end
        cycle();
        en_b = 1'b0;
        #1;
        vectors++;
        if (found == 0 || rd_en_b !== 1'b0) begin
            $display("FAIL stop_rd_en: got found=%0d rd_en=%b expected found=1 rd_en=0", found, rd_en_b);
            miscompares++;
        end
        vectors++;
        if (u_b.st_q !== RUN) begin
            $display("FAIL stop_state_run: got %0d expected %0d", u_b.st_q, RUN);
            miscompares++;
        end
        vectors++;
        if (first_rd < 0 || first_v - first_rd != 3) begin
            $display("FAIL lat2_latency: got %0d cycles expected 3", first_v - first_rd);
            miscompares++;
        end
        cycle();
        mid();
        saw_stop = (u_b.st_q == STOP);
        vectors++;
        if (!saw_stop) begin
            $display("FAIL stop_state_stop: got %0d expected %0d", u_b.st_q, STOP);
            miscompares++;
        end
        for (int i = 0; i < 20 && idle == 0; i++) begin
            cycle();
            mid();
            if (u_b.st_q == IDLE) idle = 1;
        end
        vectors++;
        if (idle == 0 || busy_b !== 1'b0) begin
            $display("FAIL stop_state_idle: got st=%0d busy=%b expected st=%0d busy=0",
                     u_b.st_q, busy_b, IDLE);
            miscompares++;
        end
        vectors++;
        if (got_b.size() != 4 || rden_cnt_b - start != 4) begin
            $display("FAIL stop_words: got %0d delivered %0d read expected 4 and 4",
                     got_b.size(), rden_cnt_b - start);
            miscompares++;
        end
        for (int k = 0; k < got_b.size() && k < 4; k++) begin
            vectors++;
            if (got_b[k] !== exp_b[k]) begin
                $display("FAIL stop_order[%0d]: got %0h expected %0h", k, got_b[k], exp_b[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int start, hit;
        hit = 0;
        cycle();
        out_ready_b = 1'b0;
        en_b = 1'b1;
        start = rden_cnt_b;
        for (int i = 0; i < 30 && hit == 0; i++) begin
            cycle();
            if (u_b.occ == 2 && u_b.infl == 1) hit = 1;
            else en_b = ((rden_cnt_b - start) < 3);
        end
        vectors++;
        if (hit == 0) begin
            $display("FAIL rst_mid_setup: got no occ=2 infl=1 cycle expected one within 30 cycles");
            miscompares++;
        end
        rst_b = 1'b1;
        fq_b.delete(); exp_b.delete(); got_b.delete();
        cycle();
        rst_b = 1'b0;
        en_b = 1'b0;
        mid();
        vectors++;
        if (out_valid_b !== 1'b0 || rd_count_b !== 4'd0 || busy_b !== 1'b0) begin
            $display("FAIL rst_mid: got valid=%b cnt=%0d busy=%b expected 0 0 0",
                     out_valid_b, rd_count_b, busy_b);
            miscompares++;
        end
    endtask

    task automatic test_counter_wrap();
        int done;
        done = 0;
        got_b.delete(); exp_b.delete();
        cycle();
        for (int k = 0; k < 17; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            fq_b.push_back(w);
            exp_b.push_back(w);
        end
        en_b = 1'b1;
        out_ready_b = 1'b1;
        for (int i = 0; i < 100 && done == 0; i++) begin
            mid();
            if (got_b.size() >= 17) done = 1;
            else cycle();
        end
        cycle();
        mid();
        vectors++;
        if (got_b.size() != 17 || rd_count_b !== 4'd1) begin
            $display("FAIL cnt_wrap: got words=%0d cnt=%0d expected words=17 cnt=1", got_b.size(), rd_count_b);
            miscompares++;
        end
        for (int k = 0; k < got_b.size() && k < 17; k++) begin
            vectors++;
            if (got_b[k] !== exp_b[k]) begin
                $display("FAIL wrap_order[%0d]: got %0h expected %0h", k, got_b[k], exp_b[k]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_stop();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
